// File: rtl/rom_access_arbiter_pkg.sv
// rom_arb_pkg: shared types and width helpers for the ROM access arbiter.
// - state_t      : arbiter FSM state (IDLE, READ)
// - port_idx_w() : width of a port index, $clog2(NUM_PORTS), at least 1
// - lat_w()      : width of the read-latency down-counter
// - burst_w()    : width of the per-grant read counter, $clog2(MAX_BURST)+1
package rom_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  function automatic int port_idx_w(input int num_ports);
    return (num_ports > 2) ? $clog2(num_ports) : 1;
  endfunction

  // Must be able to hold READ_LAT itself.
  function automatic int lat_w(input int read_lat);
    return $clog2(read_lat + 1);
  endfunction

  // A one-bit counter is kept for MAX_BURST == 0 so the declaration stays legal.
  function automatic int burst_w(input int max_burst);
    return (max_burst > 0) ? $clog2(max_burst) + 1 : 1;
  endfunction

endpackage

// File: rtl/rom_access_arbiter_if.sv
// rom_access_arbiter_if: client-side read ports plus the shared ROM port.
// - port_req/port_addr            : per-client request level and read address
// - port_gnt/port_rdata/port_rvalid : per-client grant, data register, data strobe
// - rom_addr/rom_en/rom_data      : single ROM read port
// Modport slave is the arbiter's view; master is the clients'/ROM's view.
interface rom_access_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8
);

  logic [NUM_PORTS-1:0]        port_req;
  logic [NUM_PORTS*ADDR_W-1:0] port_addr;
  logic [NUM_PORTS-1:0]        port_gnt;
  logic [NUM_PORTS*DATA_W-1:0] port_rdata;
  logic [NUM_PORTS-1:0]        port_rvalid;
  logic [ADDR_W-1:0]           rom_addr;
  logic                        rom_en;
  logic [DATA_W-1:0]           rom_data;

  modport slave (
    input  port_req, port_addr, rom_data,
    output port_gnt, port_rdata, port_rvalid, rom_addr, rom_en
  );

  modport master (
    output port_req, port_addr, rom_data,
    input  port_gnt, port_rdata, port_rvalid, rom_addr, rom_en
  );

endinterface

// File: rtl/rom_access_arbiter_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority picker.
// - req      : per-port request levels
// - last     : index of the most recently served port
// - gnt_next : one-hot winner (all zero when nothing requests)
// - idx      : binary index of the winner
// The search starts at last+1 and wraps, so the previous winner has lowest priority.
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic [NUM_PORTS-1:0] gnt_next,
  output logic [IDX_W-1:0]     idx
);

  logic found;
  int   cand;

  // NOTE: every always_comb output is given a default before the loop so no
  // path leaves a value held, which would otherwise infer a latch.
  always_comb begin
    gnt_next = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      cand = (int'(last) + off) % NUM_PORTS;
      if (!found && req[cand]) begin
        found          = 1'b1;
        gnt_next[cand] = 1'b1;
        idx            = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: shares one synchronous ROM read port among NUM_PORTS
// clients with round-robin fairness, READ_LAT-cycle reads, at most MAX_BURST
// reads per grant (0 = unlimited) and a per-port data register + valid strobe.
// - medClk : clock, all state on the rising edge
// - rst    : synchronous active-high reset
// - bus    : client and ROM signals (rom_access_arbiter_if, slave view)
module rom_access_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int READ_LAT  = 1,
  parameter int MAX_BURST = 4
) (
  input logic                  medClk,
  input logic                  rst,
  rom_access_arbiter_if.slave  bus
);

  localparam int PORT_IDX_W = port_idx_w(NUM_PORTS);
  localparam int LAT_W      = lat_w(READ_LAT);
  localparam int BURST_W    = burst_w(MAX_BURST);

  state_t                      state;
  logic [PORT_IDX_W-1:0]       last;
  logic [PORT_IDX_W-1:0]       gnt_idx;
  logic [NUM_PORTS-1:0]        gnt_r;
  logic [ADDR_W-1:0]           rom_addr_r;
  logic                        rom_en_r;
  logic [LAT_W-1:0]            lat_cnt;
  logic [BURST_W-1:0]          burst_cnt;
  logic [NUM_PORTS*DATA_W-1:0] rdata_r;
  logic [NUM_PORTS-1:0]        rvalid_r;

  logic [NUM_PORTS-1:0]        gnt_next;
  logic [PORT_IDX_W-1:0]       win_idx;
  logic                        burst_ok;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (PORT_IDX_W)
  ) u_rr (
    .req      (bus.port_req),
    .last     (last),
    .gnt_next (gnt_next),
    .idx      (win_idx)
  );

  // Room for another read in this grant; burst_cnt still holds the pre-capture count.
  assign burst_ok = (MAX_BURST == 0) || ((int'(burst_cnt) + 1) < MAX_BURST);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge medClk) begin
    if (rst) begin
      state      <= IDLE;
      last       <= PORT_IDX_W'(NUM_PORTS - 1);
      gnt_idx    <= '0;
      gnt_r      <= '0;
      rom_addr_r <= '0;
      rom_en_r   <= 1'b0;
      lat_cnt    <= '0;
      burst_cnt  <= '0;
      // NOTE: the per-port data registers are reset too; clients may read
      // port_rdata before their first rvalid and must see zero.
      rdata_r    <= '0;
      rvalid_r   <= '0;
    end else begin
      rvalid_r <= '0;
      unique case (state)
        IDLE: begin
          if (|bus.port_req) begin
            gnt_r      <= gnt_next;
            gnt_idx    <= win_idx;
            rom_addr_r <= bus.port_addr[win_idx*ADDR_W +: ADDR_W];
            rom_en_r   <= 1'b1;
            lat_cnt    <= LAT_W'(READ_LAT);
            burst_cnt  <= '0;
            state      <= READ;
          end
        end
        READ: begin
          if (lat_cnt == LAT_W'(1)) begin
            rdata_r[gnt_idx*DATA_W +: DATA_W] <= bus.rom_data;
            rvalid_r[gnt_idx]                 <= 1'b1;
            if (burst_cnt != '1) burst_cnt <= burst_cnt + 1'b1;
            if (bus.port_req[gnt_idx] && burst_ok) begin
              // Back-to-back reissue samples the port's current address.
              rom_addr_r <= bus.port_addr[gnt_idx*ADDR_W +: ADDR_W];
              lat_cnt    <= LAT_W'(READ_LAT);
            end else begin
              gnt_r    <= '0;
              rom_en_r <= 1'b0;
              last     <= gnt_idx;
              state    <= IDLE;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.port_gnt    = gnt_r;
  assign bus.port_rdata  = rdata_r;
  assign bus.port_rvalid = rvalid_r;
  assign bus.rom_addr    = rom_addr_r;
  assign bus.rom_en      = rom_en_r;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// tb_rom_access_arbiter: directed bench for rom_access_arbiter.
// Three instances cover the configurations of interest:
// - dut_a : READ_LAT=2, MAX_BURST=4 (single read, burst limit, reset mid-read)
// - dut_b : READ_LAT=1, MAX_BURST=1 (round-robin order)
// - dut_c : READ_LAT=3, MAX_BURST=0 (early drop, unlimited burst)
// The ROM is modelled as data = addr[7:0] ^ addr[15:8] ^ 8'h83 (0x1234 -> 0xA5).
// Inputs change and outputs are sampled on the falling edge.
module tb_rom_access_arbiter;

  logic medClk = 1'b0;
  logic rst    = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 medClk = ~medClk;

  rom_access_arbiter_if #(.NUM_PORTS(4), .ADDR_W(16), .DATA_W(8)) bus_a ();
  rom_access_arbiter_if #(.NUM_PORTS(4), .ADDR_W(16), .DATA_W(8)) bus_b ();
  rom_access_arbiter_if #(.NUM_PORTS(4), .ADDR_W(16), .DATA_W(8)) bus_c ();

  function automatic logic [7:0] rom_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h83;
  endfunction

  assign bus_a.rom_data = rom_f(bus_a.rom_addr);
  assign bus_b.rom_data = rom_f(bus_b.rom_addr);
  assign bus_c.rom_data = rom_f(bus_c.rom_addr);

  rom_access_arbiter #(.NUM_PORTS(4), .ADDR_W(16), .DATA_W(8), .READ_LAT(2), .MAX_BURST(4))
    dut_a (.medClk(medClk), .rst(rst), .bus(bus_a));
  rom_access_arbiter #(.NUM_PORTS(4), .ADDR_W(16), .DATA_W(8), .READ_LAT(1), .MAX_BURST(1))
    dut_b (.medClk(medClk), .rst(rst), .bus(bus_b));
  rom_access_arbiter #(.NUM_PORTS(4), .ADDR_W(16), .DATA_W(8), .READ_LAT(3), .MAX_BURST(0))
    dut_c (.medClk(medClk), .rst(rst), .bus(bus_c));

  task automatic step();
    @(negedge medClk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests_run++;
    if (bus_a.port_gnt !== 4'b0 || bus_b.port_gnt !== 4'b0 || bus_c.port_gnt !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset_gnt: got a=%b b=%b c=%b want 0000", bus_a.port_gnt, bus_b.port_gnt, bus_c.port_gnt);
    end
    tests_run++;
    if (bus_a.port_rvalid !== 4'b0 || bus_a.rom_en !== 1'b0 || bus_a.rom_addr !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_rom: got rvalid=%b en=%b addr=%h want 0000/0/0000", bus_a.port_rvalid, bus_a.rom_en, bus_a.rom_addr);
    end
    tests_run++;
    if (bus_a.port_rdata !== 32'h0 || bus_c.port_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_rdata: got a=%h c=%h want 0", bus_a.port_rdata, bus_c.port_rdata);
    end
    rst = 1'b0;
    step();
  endtask

  // Port 2, address 0x1234, READ_LAT=2: capture two edges after the grant.
  task automatic test_single();
    bus_a.port_req           = 4'b0100;
    bus_a.port_addr[32 +: 16] = 16'h1234;
    step();
    tests_run++;
    if (bus_a.port_gnt !== 4'b0100 || bus_a.rom_addr !== 16'h1234 || bus_a.rom_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_grant: got gnt=%b addr=%h en=%b want 0100/1234/1", bus_a.port_gnt, bus_a.rom_addr, bus_a.rom_en);
    end
    // Address change and request drop must not disturb the read in flight.
    bus_a.port_req            = 4'b0000;
    bus_a.port_addr[32 +: 16] = 16'hFFFF;
    step();
    tests_run++;
    if (bus_a.port_rvalid !== 4'b0 || bus_a.port_gnt !== 4'b0100 || bus_a.rom_addr !== 16'h1234) begin
      tests_failed++;
      $display("FAIL single_wait: got rvalid=%b gnt=%b addr=%h want 0000/0100/1234", bus_a.port_rvalid, bus_a.port_gnt, bus_a.rom_addr);
    end
    step();
    tests_run++;
    if (bus_a.port_rvalid !== 4'b0100 || bus_a.port_rdata[16 +: 8] !== 8'hA5) begin
      tests_failed++;
      $display("FAIL single_capture: got rvalid=%b rdata2=%h want 0100/a5", bus_a.port_rvalid, bus_a.port_rdata[16 +: 8]);
    end
    tests_run++;
    if (bus_a.port_gnt !== 4'b0 || bus_a.rom_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_release: got gnt=%b en=%b want 0000/0", bus_a.port_gnt, bus_a.rom_en);
    end
    step();
    tests_run++;
    if (bus_a.port_rvalid !== 4'b0 || bus_a.port_rdata[16 +: 8] !== 8'hA5) begin
      tests_failed++;
      $display("FAIL single_hold: got rvalid=%b rdata2=%h want 0000/a5", bus_a.port_rvalid, bus_a.port_rdata[16 +: 8]);
    end
  endtask

  // Ports 0, 1, 3 hold requests with MAX_BURST=1: one read per grant in rotation.
  task automatic test_round_robin();
    int order [6] = '{0, 1, 3, 0, 1, 3};
    logic [15:0] rr_addr [4] = '{16'h1001, 16'h2052, 16'h3000, 16'h40C7};
    logic [3:0] exp_gnt;
    for (int i = 0; i < 4; i++) bus_b.port_addr[i*16 +: 16] = rr_addr[i];
    bus_b.port_req = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      exp_gnt = 4'b0001 << order[k];
      step();
      tests_run++;
      if (bus_b.port_gnt !== exp_gnt || bus_b.port_rvalid !== 4'b0 || bus_b.rom_addr !== rr_addr[order[k]]) begin
        tests_failed++;
        $display("FAIL rr_grant[%0d]: got gnt=%b rvalid=%b addr=%h want %b/0000/%h", k, bus_b.port_gnt, bus_b.port_rvalid, bus_b.rom_addr, exp_gnt, rr_addr[order[k]]);
      end
      if (k == 5) bus_b.port_req = 4'b0000;
      step();
      tests_run++;
      if (bus_b.port_rvalid !== exp_gnt || bus_b.port_gnt !== 4'b0 || bus_b.port_rdata[order[k]*8 +: 8] !== rom_f(rr_addr[order[k]])) begin
        tests_failed++;
        $display("FAIL rr_capture[%0d]: got rvalid=%b gnt=%b rdata=%h want %b/0000/%h", k, bus_b.port_rvalid, bus_b.port_gnt, bus_b.port_rdata[order[k]*8 +: 8], exp_gnt, rom_f(rr_addr[order[k]]));
      end
    end
    step();
    tests_run++;
    if (bus_b.port_gnt !== 4'b0 || bus_b.port_rvalid !== 4'b0) begin
      tests_failed++;
      $display("FAIL rr_idle: got gnt=%b rvalid=%b want 0000/0000", bus_b.port_gnt, bus_b.port_rvalid);
    end
  endtask

  // Port 1 bursts 4 reads (address bumped before each reissue), then port 0 gets the grant.
  task automatic test_burst();
    bus_a.port_req            = 4'b0010;
    bus_a.port_addr[16 +: 16] = 16'h2000;
    bus_a.port_addr[0 +: 16]  = 16'h3000;
    step();
    tests_run++;
    if (bus_a.port_gnt !== 4'b0010 || bus_a.rom_addr !== 16'h2000) begin
      tests_failed++;
      $display("FAIL burst_grant: got gnt=%b addr=%h want 0010/2000", bus_a.port_gnt, bus_a.rom_addr);
    end
    bus_a.port_req = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      bus_a.port_addr[16 +: 16] = 16'h2000 + 16'(k + 1);
      step();
      tests_run++;
      if (bus_a.port_rvalid !== 4'b0 || bus_a.port_gnt !== 4'b0010) begin
        tests_failed++;
        $display("FAIL burst_wait[%0d]: got rvalid=%b gnt=%b want 0000/0010", k, bus_a.port_rvalid, bus_a.port_gnt);
      end
      step();
      tests_run++;
      if (bus_a.port_rvalid !== 4'b0010 || bus_a.port_rdata[8 +: 8] !== rom_f(16'h2000 + 16'(k))) begin
        tests_failed++;
        $display("FAIL burst_capture[%0d]: got rvalid=%b rdata1=%h want 0010/%h", k, bus_a.port_rvalid, bus_a.port_rdata[8 +: 8], rom_f(16'h2000 + 16'(k)));
      end
      if (k < 3) begin
        tests_run++;
        if (bus_a.port_gnt !== 4'b0010 || bus_a.rom_addr !== 16'h2000 + 16'(k + 1)) begin
          tests_failed++;
          $display("FAIL burst_reissue[%0d]: got gnt=%b addr=%h want 0010/%h", k, bus_a.port_gnt, bus_a.rom_addr, 16'h2000 + 16'(k + 1));
        end
      end else begin
        tests_run++;
        if (bus_a.port_gnt !== 4'b0 || bus_a.rom_en !== 1'b0) begin
          tests_failed++;
          $display("FAIL burst_release: got gnt=%b en=%b want 0000/0", bus_a.port_gnt, bus_a.rom_en);
        end
      end
    end
    step();
    tests_run++;
    if (bus_a.port_gnt !== 4'b0001 || bus_a.rom_addr !== 16'h3000) begin
      tests_failed++;
      $display("FAIL burst_next: got gnt=%b addr=%h want 0001/3000", bus_a.port_gnt, bus_a.rom_addr);
    end
    bus_a.port_req = 4'b0000;
    step();
    step();
    tests_run++;
    if (bus_a.port_rvalid !== 4'b0001 || bus_a.port_gnt !== 4'b0 || bus_a.port_rdata[0 +: 8] !== rom_f(16'h3000)) begin
      tests_failed++;
      $display("FAIL burst_p0_capture: got rvalid=%b gnt=%b rdata0=%h want 0001/0000/%h", bus_a.port_rvalid, bus_a.port_gnt, bus_a.port_rdata[0 +: 8], rom_f(16'h3000));
    end
    step();
  endtask

  // Port 0 drops its request right after the grant; READ_LAT=3 read still completes.
  task automatic test_early_drop();
    bus_c.port_req           = 4'b0001;
    bus_c.port_addr[0 +: 16] = 16'h0042;
    step();
    tests_run++;
    if (bus_c.port_gnt !== 4'b0001 || bus_c.rom_addr !== 16'h0042) begin
      tests_failed++;
      $display("FAIL drop_grant: got gnt=%b addr=%h want 0001/0042", bus_c.port_gnt, bus_c.rom_addr);
    end
    bus_c.port_req = 4'b0000;
    step();
    step();
    tests_run++;
    if (bus_c.port_rvalid !== 4'b0 || bus_c.port_gnt !== 4'b0001) begin
      tests_failed++;
      $display("FAIL drop_hold: got rvalid=%b gnt=%b want 0000/0001", bus_c.port_rvalid, bus_c.port_gnt);
    end
    step();
    tests_run++;
    if (bus_c.port_rvalid !== 4'b0001 || bus_c.port_rdata[0 +: 8] !== rom_f(16'h0042) || bus_c.port_gnt !== 4'b0) begin
      tests_failed++;
      $display("FAIL drop_capture: got rvalid=%b rdata0=%h gnt=%b want 0001/%h/0000", bus_c.port_rvalid, bus_c.port_rdata[0 +: 8], bus_c.port_gnt, rom_f(16'h0042));
    end
    step();
    tests_run++;
    if (bus_c.rom_en !== 1'b0 || bus_c.port_rvalid !== 4'b0) begin
      tests_failed++;
      $display("FAIL drop_no_reissue: got en=%b rvalid=%b want 0/0000", bus_c.rom_en, bus_c.port_rvalid);
    end
  endtask

  // MAX_BURST=0: port 2 holds the grant for 10 reads, one every 3 cycles.
  task automatic test_unlimited();
    bus_c.port_req            = 4'b0100;
    bus_c.port_addr[32 +: 16] = 16'h4000;
    step();
    for (int k = 0; k < 10; k++) begin
      bus_c.port_addr[32 +: 16] = 16'h4000 + 16'(k + 1);
      step();
      step();
      tests_run++;
      if (bus_c.port_rvalid !== 4'b0 || bus_c.port_gnt !== 4'b0100) begin
        tests_failed++;
        $display("FAIL unl_wait[%0d]: got rvalid=%b gnt=%b want 0000/0100", k, bus_c.port_rvalid, bus_c.port_gnt);
      end
      step();
      tests_run++;
      if (bus_c.port_rvalid !== 4'b0100 || bus_c.port_gnt !== 4'b0100 || bus_c.port_rdata[16 +: 8] !== rom_f(16'h4000 + 16'(k))) begin
        tests_failed++;
        $display("FAIL unl_capture[%0d]: got rvalid=%b gnt=%b rdata2=%h want 0100/0100/%h", k, bus_c.port_rvalid, bus_c.port_gnt, bus_c.port_rdata[16 +: 8], rom_f(16'h4000 + 16'(k)));
      end
    end
    bus_c.port_req = 4'b0000;
    step();
    step();
    step();
    tests_run++;
    if (bus_c.port_rvalid !== 4'b0100 || bus_c.port_gnt !== 4'b0 || bus_c.port_rdata[16 +: 8] !== rom_f(16'h400A)) begin
      tests_failed++;
      $display("FAIL unl_release: got rvalid=%b gnt=%b rdata2=%h want 0100/0000/%h", bus_c.port_rvalid, bus_c.port_gnt, bus_c.port_rdata[16 +: 8], rom_f(16'h400A));
    end
    step();
  endtask

  // Reset one cycle before the capture edge kills the read; then port 0 beats port 3.
  task automatic test_reset_mid_read();
    bus_a.port_req            = 4'b0100;
    bus_a.port_addr[32 +: 16] = 16'h5555;
    step();
    tests_run++;
    if (bus_a.port_gnt !== 4'b0100) begin
      tests_failed++;
      $display("FAIL rst_mid_grant: got gnt=%b want 0100", bus_a.port_gnt);
    end
    rst = 1'b1;
    bus_a.port_req = 4'b0000;
    step();
    tests_run++;
    if (bus_a.port_gnt !== 4'b0 || bus_a.rom_en !== 1'b0 || bus_a.rom_addr !== 16'h0 || bus_a.port_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_clear: got gnt=%b en=%b addr=%h rdata=%h want all zero", bus_a.port_gnt, bus_a.rom_en, bus_a.rom_addr, bus_a.port_rdata);
    end
    step();
    tests_run++;
    if (bus_a.port_rvalid !== 4'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_rvalid: got rvalid=%b want 0000", bus_a.port_rvalid);
    end
    rst = 1'b0;
    bus_a.port_addr[0 +: 16]  = 16'h0A0A;
    bus_a.port_addr[48 +: 16] = 16'h0B0B;
    bus_a.port_req = 4'b1001;
    step();
    tests_run++;
    if (bus_a.port_gnt !== 4'b0001 || bus_a.rom_addr !== 16'h0A0A) begin
      tests_failed++;
      $display("FAIL rst_first_prio: got gnt=%b addr=%h want 0001/0a0a", bus_a.port_gnt, bus_a.rom_addr);
    end
    bus_a.port_req = 4'b0000;
    step();
    step();
    step();
  endtask

  initial begin
    bus_a.port_req = '0; bus_a.port_addr = '0;
    bus_b.port_req = '0; bus_b.port_addr = '0;
    bus_c.port_req = '0; bus_c.port_addr = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_early_drop();
    test_unlimited();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/rom_access_arbiter.md
# rom_access_arbiter

Parametrised N-port arbiter that shares one synchronous ROM/disk read port among requesting clients. It replaces the fixed two-port access controller with four additions: round-robin fairness, configurable ROM read latency, bounded burst length per grant, and per-port registered read data with a valid strobe. It sits between the task engines' read ports and the single ROM data bus, all on `medClk`.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of client ports, ≥2.
- `ADDR_W`, 16: ROM address width.
- `DATA_W`, 8: ROM data width.
- `READ_LAT`, 1: cycles from `rom_addr` update to `rom_data` sample, ≥1.
- `MAX_BURST`, 4: reads per grant before forced release; 0 = unlimited.

Ports (one clock; reset is synchronous and active-high):
- `medClk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `port_req`  in  NUM_PORTS  per-port request level.
- `port_addr`  in  NUM_PORTS*ADDR_W  per-port read address; port i at [i*ADDR_W +: ADDR_W].
- `port_gnt`  out  NUM_PORTS  one-hot grant, at most one bit set.
- `port_rdata`  out  NUM_PORTS*DATA_W  per-port data register; holds last value read for that port.
- `port_rvalid`  out  NUM_PORTS  one-cycle pulse when that port's `port_rdata` updates.
- `rom_addr`  out  ADDR_W  registered ROM address.
- `rom_en`  out  1  high while a read is outstanding.
- `rom_data`  in  DATA_W  ROM read data.

## Operation
- States: IDLE, READ.
- IDLE: if any `port_req` set, pick the winner by rotating priority, starting at `last+1` mod NUM_PORTS. On the same edge: set `port_gnt[winner]`, `rom_addr <= port_addr[winner]`, `rom_en <= 1`, `lat_cnt <= READ_LAT`, `burst_cnt <= 0`, go to READ. With no request, stay in IDLE.
- READ: each edge decrements `lat_cnt`. On the edge where `lat_cnt == 1` (the capture edge): `port_rdata[g] <= rom_data`, `port_rvalid[g] <= 1` for one cycle, `burst_cnt++`.
- On the capture edge, if `port_req[g]` is still high and (MAX_BURST==0 or `burst_cnt+1 < MAX_BURST`): `rom_addr <= port_addr[g]` (current value), `lat_cnt <= READ_LAT`, stay in READ. Otherwise release: `port_gnt <= 0`, `rom_en <= 0`, `last <= g`, go to IDLE.
- If `port_req` drops mid-read, the in-flight read still completes and its data is delivered. The grant holds until the capture edge.
- `port_addr` changes during READ do not affect the read in flight. The address is sampled only on grant and on back-to-back reissue.
- `burst_cnt` is width clog2(MAX_BURST)+1 and saturates. It is unused when MAX_BURST==0.

## Timing
- Reset values: `port_gnt`=0, `port_rvalid`=0, `port_rdata`=0, `rom_addr`=0, `rom_en`=0, state IDLE, `last`=NUM_PORTS-1 so port 0 has first priority. Reset overrides any in-flight read; no rvalid is emitted for it.
- Request at edge E0 in IDLE → `port_gnt`/`rom_addr` valid after E0. Capture at edge E0+READ_LAT. `port_rvalid` is high during the cycle after that edge.
- Back-to-back throughput within a grant: one read per READ_LAT cycles.
- Release to next grant: minimum one IDLE cycle.
- Simultaneous requests: highest rotating priority wins. All other requests wait and are not lost.
- Bounded wait: any port waits at most (NUM_PORTS-1) grants when MAX_BURST>0.

## Structure
- Package `rom_arb_pkg`: state enum (IDLE, READ) and the width helpers `PORT_IDX_W = $clog2(NUM_PORTS)`, `LAT_W`, `BURST_W`.
- Sub-module `rr_arbiter`: combinational rotating-priority picker. Inputs: `req`, `last`. Outputs: one-hot `gnt_next` and `idx`. The top level owns the FSM, counters and datapath.

## Test plan
- Single request, READ_LAT=2: port 2 req, addr 0x1234 at E0 → `port_gnt`=4'b0100 and `rom_addr`=0x1234 after E0. `rom_data`=0xA5 at E2 → `port_rdata[2]`=0xA5 and one-cycle `port_rvalid[2]`.
- Round-robin: ports 0, 1 and 3 hold req, MAX_BURST=1 → grants follow 0,1,3,0,1,3. Each grant carries exactly one rvalid.
- Burst limit: MAX_BURST=4, port 1 holds req with addr incrementing per reissue → exactly 4 rvalids, then release. Port 0 (also requesting) is granted next, after one IDLE cycle.
- Early drop: port 0 drops req the cycle after grant, READ_LAT=3 → data is still delivered at E3, then release with no reissue.
- Reset mid-read: assert `rst` one cycle before capture → no rvalid, all outputs zero. After reset, ports 0 and 3 request together → port 0 is granted first.
- MAX_BURST=0: single port holds req for 10 reads → grant stays continuous, 10 rvalids spaced READ_LAT apart.
